keyb_scanner: RTL and testbench

Matrix-keypad scanner for the calculator front end. It drives the columns of a 4x4 keypad and samples the rows, debounces contacts, and produces a clean one-cycle `btn_press` pulse with a 4-bit `btn_id`. It is the producer side of the keypad-decoder interface: `btn_press` feeds `btn_press_in`, and `btn_id` feeds `btn_id` directly.

---
 rtl/keyb_scanner.sv | 221 ++++++++++++++++++++++
 tb/tb_keyb_scanner.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keyb_scanner.sv
// 4x4 matrix-keypad scanner: column drive, debounce, one-cycle press pulse with key id.
// Optional auto-repeat while a key is held: define KEYB_AUTOREPEAT_EN.
module keyb_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_N     = 10,
    parameter int REPEAT_DELAY_N = 500,
    parameter int REPEAT_RATE_N  = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       btn_press,
    output logic [3:0] btn_id,
    output logic       key_down
);

    localparam int TW = $clog2(SCAN_DIV) + 1;
    localparam int CW = $clog2(DEBOUNCE_N) + 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LIM   = CW'(DEBOUNCE_N);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // Reject parameter values the scan timing cannot support.
    if (SCAN_DIV < 4 || DEBOUNCE_N < 1 || REPEAT_DELAY_N < 1 || REPEAT_RATE_N < 1) begin : g_param_check
        $error("keyb_scanner: parameter out of range");
    end

    // Lowest-index pressed row wins when several rows are low.
    function automatic logic [1:0] first_low(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0]) begin
            idx = 2'd0;
        end else if (!rows[1]) begin
            idx = 2'd1;
        end else if (!rows[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    logic [3:0]    row_meta;
    logic [3:0]    row_s;
    logic [TW-1:0] tick;
    logic          sample_s;
    state_t        state, state_next;
    logic [1:0]    col, col_next;
    logic [1:0]    cand_row, cand_row_next;
    logic [1:0]    cand_col, cand_col_next;
    logic [CW-1:0] cnt, cnt_next, cnt_inc_s;
    logic [CW-1:0] rel_cnt, rel_cnt_next, rel_inc_s;
    logic          accept_s, release_s, repeat_s;
    logic          btn_press_next;
    logic [3:0]    btn_id_next;
    logic          key_down_next;

`ifdef KEYB_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY_N > REPEAT_RATE_N) ? REPEAT_DELAY_N : REPEAT_RATE_N;
    localparam int RW = $clog2(REP_MAX) + 1;
    logic [RW-1:0] rep_cnt, rep_cnt_next, rep_inc_s, rep_lim_s;
    logic          rep_phase, rep_phase_next;

    assign rep_inc_s = (rep_cnt == {RW{1'b1}}) ? rep_cnt : rep_cnt + RW'(1);
    assign rep_lim_s = rep_phase ? RW'(REPEAT_RATE_N) : RW'(REPEAT_DELAY_N);
`endif

    assign sample_s  = (tick == TICK_LAST);
    assign cnt_inc_s = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
    assign rel_inc_s = (rel_cnt == {CW{1'b1}}) ? rel_cnt : rel_cnt + CW'(1);

    // Next-state, column and counter decisions, all taken only at the sample point.
    always_comb begin
        state_next    = state;
        col_next      = col;
        cand_row_next = cand_row;
        cand_col_next = cand_col;
        cnt_next      = cnt;
        rel_cnt_next  = rel_cnt;
        accept_s      = 1'b0;
        release_s     = 1'b0;
        repeat_s      = 1'b0;
`ifdef KEYB_AUTOREPEAT_EN
        rep_cnt_next   = rep_cnt;
        rep_phase_next = rep_phase;
`endif
        if (sample_s) begin
            case (state)
                SCAN: begin
                    if (row_s != 4'hF) begin
                        cand_row_next = first_low(row_s);
                        cand_col_next = col;
                        cnt_next      = CW'(1);
                        if (DEB_LIM == CW'(1)) begin
                            accept_s   = 1'b1;
                            state_next = HELD;
                        end else begin
                            state_next = DEBOUNCE;
                        end
                    end else begin
                        col_next = col + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!row_s[cand_row]) begin
                        cnt_next = cnt_inc_s;
                        if (cnt_inc_s == DEB_LIM) begin
                            accept_s   = 1'b1;
                            state_next = HELD;
                        end else begin
                            state_next = DEBOUNCE;
                        end
                    end else begin
                        state_next = SCAN;
                        col_next   = col + 2'd1;
                    end
                end
                HELD: begin
                    if (row_s[cand_row]) begin
                        rel_cnt_next = rel_inc_s;
`ifdef KEYB_AUTOREPEAT_EN
                        rep_cnt_next   = '0;
                        rep_phase_next = 1'b0;
`endif
                        if (rel_inc_s == DEB_LIM) begin
                            release_s    = 1'b1;
                            rel_cnt_next = '0;
                            state_next   = SCAN;
                            col_next     = col + 2'd1;
                        end else begin
                            state_next = HELD;
                        end
                    end else begin
                        rel_cnt_next = '0;
`ifdef KEYB_AUTOREPEAT_EN
                        // First repeat after the delay, then one per rate interval.
                        if (rep_inc_s == rep_lim_s) begin
                            repeat_s       = 1'b1;
                            rep_cnt_next   = '0;
                            rep_phase_next = 1'b1;
                        end else begin
                            rep_cnt_next = rep_inc_s;
                        end
`endif
                    end
                end
                default: begin
                    state_next = SCAN;
                    col_next   = 2'd0;
                end
            endcase
        end else begin
            state_next = state;
        end

        btn_press_next = accept_s | repeat_s;
        btn_id_next    = btn_id;
        key_down_next  = key_down;
        if (accept_s) begin
            btn_id_next   = {cand_col_next, cand_row_next};
            key_down_next = 1'b1;
            rel_cnt_next  = '0;
`ifdef KEYB_AUTOREPEAT_EN
            rep_cnt_next   = '0;
            rep_phase_next = 1'b0;
`endif
        end else if (release_s) begin
            key_down_next = 1'b0;
        end else begin
            key_down_next = key_down;
        end
    end

    // Synchronizer, slot timer, FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta  <= 4'hF;
            row_s     <= 4'hF;
            tick      <= '0;
            state     <= SCAN;
            col       <= 2'd0;
            col_n     <= 4'b1110;
            cand_row  <= 2'd0;
            cand_col  <= 2'd0;
            cnt       <= '0;
            rel_cnt   <= '0;
            btn_press <= 1'b0;
            btn_id    <= 4'd0;
            key_down  <= 1'b0;
`ifdef KEYB_AUTOREPEAT_EN
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
`endif
        end else begin
            row_meta  <= row_n;
            row_s     <= row_meta;
            tick      <= sample_s ? '0 : tick + TW'(1);
            state     <= state_next;
            col       <= col_next;
            col_n     <= ~(4'b0001 << col_next);
            cand_row  <= cand_row_next;
            cand_col  <= cand_col_next;
            cnt       <= cnt_next;
            rel_cnt   <= rel_cnt_next;
            btn_press <= btn_press_next;
            btn_id    <= btn_id_next;
            key_down  <= key_down_next;
`ifdef KEYB_AUTOREPEAT_EN
            rep_cnt   <= rep_cnt_next;
            rep_phase <= rep_phase_next;
`endif
        end
    end

endmodule

// File: tb/tb_keyb_scanner.sv
// Directed bench for keyb_scanner with SCAN_DIV=4, DEBOUNCE_N=3 and a behavioural 4x4 keypad.
// Expected repeat behaviour follows KEYB_AUTOREPEAT_EN (REPEAT_DELAY_N=5, REPEAT_RATE_N=2).
module tb_keyb_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       btn_press;
    logic [3:0] btn_id;
    logic       key_down;
    logic [15:0] keys;

    int tests = 0;
    int fails = 0;
    int cycle_cnt = 0;
    int pulse_cnt = 0;
    int id_err = 0;
    int pulse_t[$];
    logic [3:0] exp_id_mon = 4'd0;

`ifdef KEYB_AUTOREPEAT_EN
    localparam int PULSES_LONG = 3;
    localparam int PULSES_REP  = 5;
`else
    localparam int PULSES_LONG = 1;
    localparam int PULSES_REP  = 1;
`endif

    typedef struct {
        int         c;
        int         r;
        logic [3:0] id;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    keyb_scanner #(
        .SCAN_DIV(4), .DEBOUNCE_N(3), .REPEAT_DELAY_N(5), .REPEAT_RATE_N(2)
    ) dut (
        .clk(clk), .reset(reset), .row_n(row_n), .col_n(col_n),
        .btn_press(btn_press), .btn_id(btn_id), .key_down(key_down)
    );

    // Keypad: a closed key (c,r) pulls row r low while column c is driven.
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[c*4+r] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Pulse monitor: counts pulses, records their cycle, flags wrong ids.
    always @(negedge clk) begin
        if (btn_press) begin
            pulse_cnt <= pulse_cnt + 1;
            pulse_t.push_back(cycle_cnt);
            if (btn_id != exp_id_mon) id_err <= id_err + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the first negedge on which col_n has just switched to target.
    task automatic wait_col(input logic [3:0] target);
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        prev = col_n;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (col_n == target && prev != target) found = 1'b1;
            prev = col_n;
        end
        check("col_reached", 32'(found), 32'd1);
    endtask

    task automatic press_release(input int c, input int r, input logic [3:0] id);
        int base;
        int ebase;
        logic [3:0] t;
        logic [3:0] one;
        one = 4'b0001;
        t = ~(one << c);
        base = pulse_cnt;
        ebase = id_err;
        exp_id_mon = id;
        wait_col(t);
        keys[c*4+r] = 1'b1;
        cyc(11);
        check("no_early_press", 32'(btn_press), 32'd0);
        cyc(1);
        check("press_pulse", 32'(btn_press), 32'd1);
        check("press_id", 32'(btn_id), 32'(id));
        check("key_down_set", 32'(key_down), 32'd1);
        cyc(1);
        check("pulse_width", 32'(btn_press), 32'd0);
        cyc(27);
        keys = 16'h0000;
        cyc(11);
        check("key_down_hold", 32'(key_down), 32'd1);
        cyc(1);
        check("key_down_fall", 32'(key_down), 32'd0);
        cyc(20);
        check("pulse_count", 32'(pulse_cnt - base), 32'(PULSES_LONG));
        check("pulse_ids", 32'(id_err - ebase), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int qb;
        int gaps[4];
        logic [3:0] cols[5];
        vecs[0] = '{1, 3, 4'd7};
        vecs[1] = '{0, 0, 4'd0};
        vecs[2] = '{2, 2, 4'd10};
        vecs[3] = '{3, 3, 4'd15};
        vecs[4] = '{0, 2, 4'd2};
        cols = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        gaps = '{20, 28, 36, 44};

        keys = 16'h0000;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_col_n", 32'(col_n), 32'hE);
        check("rst_btn_press", 32'(btn_press), 32'd0);
        check("rst_btn_id", 32'(btn_id), 32'd0);
        check("rst_key_down", 32'(key_down), 32'd0);
        cyc(2);
        for (int i = 0; i < 5; i++) begin
            check("col_cycle", 32'(col_n), 32'(cols[i]));
            cyc(4);
        end

        // Table of clean single-key presses.
        for (int i = 0; i < 5; i++) press_release(vecs[i].c, vecs[i].r, vecs[i].id);

        // Bounce on (0,0): low for two samples only.
        base = pulse_cnt;
        wait_col(4'b1110);
        keys[0] = 1'b1;
        cyc(6);
        check("deb_col_hold", 32'(col_n), 32'hE);
        cyc(2);
        keys = 16'h0000;
        cyc(3);
        check("bounce_col_still", 32'(col_n), 32'hE);
        cyc(1);
        check("bounce_resume_col1", 32'(col_n), 32'hD);
        cyc(20);
        check("bounce_no_pulse", 32'(pulse_cnt - base), 32'd0);
        check("bounce_key_down", 32'(key_down), 32'd0);

        // Keys (2,0) and (2,2) together: lowest row wins.
        base = pulse_cnt;
        exp_id_mon = 4'd8;
        wait_col(4'b1011);
        keys[8] = 1'b1;
        keys[10] = 1'b1;
        cyc(12);
        check("multi_press", 32'(btn_press), 32'd1);
        check("multi_id", 32'(btn_id), 32'd8);
        cyc(16);
        keys = 16'h0000;
        cyc(24);
        check("multi_one_pulse", 32'(pulse_cnt - base), 32'd1);
        check("multi_key_down", 32'(key_down), 32'd0);
        press_release(2, 2, 4'd10);

        // Reset one sample before acceptance.
        base = pulse_cnt;
        wait_col(4'b1101);
        keys[5] = 1'b1;
        cyc(11);
        reset = 1'b1;
        cyc(1);
        check("rst_deb_col_n", 32'(col_n), 32'hE);
        check("rst_deb_press", 32'(btn_press), 32'd0);
        check("rst_deb_key_down", 32'(key_down), 32'd0);
        keys = 16'h0000;
        cyc(1);
        reset = 1'b0;
        cyc(40);
        check("rst_deb_no_pulse", 32'(pulse_cnt - base), 32'd0);

        // Reset while held drops key_down.
        base = pulse_cnt;
        exp_id_mon = 4'd1;
        wait_col(4'b1110);
        keys[1] = 1'b1;
        cyc(12);
        check("held_key_down", 32'(key_down), 32'd1);
        cyc(8);
        reset = 1'b1;
        cyc(1);
        check("rst_held_key_down", 32'(key_down), 32'd0);
        check("rst_held_btn_id", 32'(btn_id), 32'd0);
        keys = 16'h0000;
        cyc(1);
        reset = 1'b0;
        cyc(20);
        check("rst_held_pulses", 32'(pulse_cnt - base), 32'd1);

        // Key (3,1) held 12 samples after acceptance.
        base = pulse_cnt;
        qb = pulse_t.size();
        exp_id_mon = 4'd13;
        wait_col(4'b0111);
        keys[13] = 1'b1;
        cyc(12);
        check("rep_first_press", 32'(btn_press), 32'd1);
        check("rep_first_id", 32'(btn_id), 32'd13);
        cyc(46);
        keys = 16'h0000;
        cyc(24);
        check("rep_pulse_count", 32'(pulse_cnt - base), 32'(PULSES_REP));
        check("rep_ids", 32'(id_err), 32'd0);
        check("rep_key_down", 32'(key_down), 32'd0);
`ifdef KEYB_AUTOREPEAT_EN
        if (pulse_t.size() >= qb + 5) begin
            for (int k = 0; k < 4; k++) check("rep_gap", 32'(pulse_t[qb+k+1] - pulse_t[qb]), 32'(gaps[k]));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
